// File: rtl/ice_uart_pkg.sv
// Shared definitions for the ice UART receive path: FSM state codes,
// frame width and parameter legality helpers.
package ice_uart_pkg;

  localparam int DATA_BITS = 8;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_STOP  = 3'd3;
  localparam state_t ST_BREAK = 3'd4;

  // Need at least 4 clocks per bit so the half-bit load (H-1) is non-zero
  // and the sample point sits clear of the synchronizer delay.
  function automatic bit cpb_legal(input int cpb);
    return cpb >= 4;
  endfunction

  function automatic bit fifo_depth_legal(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word-fall-through receive FIFO. Head entry is driven straight
// from the storage flops. Pointers carry one extra wrap bit so full/empty
// are distinguished without a counter. A push while full is accepted only
// when a pop in the same cycle frees the slot.
module uart_rx_fifo
  import ice_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] data,
  output logic                 empty,
  output logic                 full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                       wr_q, rd_q;
  logic [DEPTH-1:0][DATA_BITS-1:0]   mem_q;
  logic                              do_pop, do_push;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign data    = mem_q[rd_q[AW-1:0]];

  // Pointer update; both may move in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Entry write; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
    end else if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready byte output.
// Build option: define UART_RX_FIFO_EN to buffer bytes in a FIFO_DEPTH
// entry FIFO; otherwise a single holding register is used. Both builds
// present the first byte on the same cycle.
module uart_rx
  import ice_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 20,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] H_LD   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] N_LD   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_B = BW'(DATA_BITS - 1);

  if (!cpb_legal(CLKS_PER_BIT)) begin : g_bad_cpb
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end
  if (!fifo_depth_legal(FIFO_DEPTH)) begin : g_bad_depth
    $error("uart_rx: FIFO_DEPTH must be a power of 2, at least 2");
  end

  logic [1:0]           sync_q;
  logic                 rx_s;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 push;

  assign rx_s        = sync_q[1];
  assign busy        = (state_q != ST_IDLE);
  assign framing_err = fe_q;
  assign overrun     = ov_q;

  // Two-flop synchronizer, preset to the idle-high line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx_pin};
  end

  // Frame FSM: counter counts down to each mid-bit sample point.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    fe_d    = 1'b0;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = H_LD;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            state_d = ST_IDLE;          // too short to be a start bit
          end else begin
            state_d = ST_DATA;
            cnt_d   = N_LD;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};   // LSB first
          cnt_d   = N_LD;
          if (bit_q == LAST_B) state_d = ST_STOP;
          else                 bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_BREAK: begin
        // A held-low line reports one framing error, then waits for idle.
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

`ifdef UART_RX_FIFO_EN
  logic fifo_empty, fifo_full, pop;

  assign pop      = rx_ready & ~fifo_empty;
  assign rx_valid = ~fifo_empty;
  assign ov_d     = push & fifo_full & ~pop;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shift_q),
    .pop       (pop),
    .data      (rx_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );
`else
  logic                 hold_full_q;
  logic [DATA_BITS-1:0] hold_q;
  logic                 pop;

  assign pop      = rx_ready & hold_full_q;
  assign rx_valid = hold_full_q;
  assign rx_data  = hold_q;
  assign ov_d     = push & hold_full_q & ~pop;

  // Single holding register; a same-cycle pop makes room for the push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_full_q <= 1'b0;
      hold_q      <= '0;
    end else if (push && (!hold_full_q || pop)) begin
      hold_full_q <= 1'b1;
      hold_q      <= shift_q;
    end else if (pop) begin
      hold_full_q <= 1'b0;
    end
  end
`endif

  // Status pulses, registered so they appear the cycle after the stop sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      fe_q <= fe_d;
      ov_q <= ov_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT=8. Stimulus pushes expected
// bytes; a negedge monitor pops and compares on every rx_valid&rx_ready.
module tb_uart_rx;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_pin = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, framing_err, overrun, busy;

  uart_rx #(.CLKS_PER_BIT(N), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_pin      (rx_pin),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .framing_err (framing_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int nchk = 0, npass = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int fe_cnt, fe_cyc, ov_cnt, ov_cyc, rise_cnt, rise_cyc, vhi_cnt, fall_cyc;
  logic prev_v = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    nchk++;
    if (got == exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic clr();
    fe_cnt = 0; ov_cnt = 0; rise_cnt = 0; vhi_cnt = 0;
    fe_cyc = -1000; ov_cyc = -1000; rise_cyc = -1000;
  endtask

  // Call at a posedge; drives one bit period starting 1 time unit later.
  task automatic drive_bit(input logic v);
    #1 rx_pin = v;
    repeat (N) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    #1 rx_pin = 1'b0;
    fall_cyc = cyc;
    repeat (N) @(posedge clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      prev_v = 1'b0;
    end else begin
      if (rx_valid && !prev_v) begin rise_cnt++; rise_cyc = cyc; end
      if (rx_valid) vhi_cnt++;
      prev_v = rx_valid;
      if (framing_err) begin fe_cnt++; fe_cyc = cyc; end
      if (overrun)     begin ov_cnt++; ov_cyc = cyc; end
      if (rx_valid && rx_ready) begin
        check("sb_byte_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          check("sb_rx_data", rx_data, exp_b);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_framing_err", framing_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (4) @(posedge clk);

    // 1: single byte, exact latency and one-cycle valid with ready high
    #1 rx_ready = 1'b1; clr();
    @(posedge clk);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    repeat (4) @(posedge clk);
    check("t1_rise_cnt", rise_cnt, 1);
    check("t1_latency", rise_cyc - fall_cyc, 79);
    check("t1_valid_cycles", vhi_cnt, 1);
    check("t1_framing", fe_cnt, 0);
    check("t1_overrun", ov_cnt, 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // 2: 3-cycle glitch rejected at the start sample
    clr();
    @(posedge clk);
    #1 rx_pin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_pin = 1'b1;
    @(negedge clk);
    check("t2_busy_c3", busy, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t2_busy_c6", busy, 1);
    @(negedge clk);
    check("t2_busy_c7", busy, 0);
    repeat (20) @(posedge clk);
    check("t2_no_valid", rise_cnt, 0);
    check("t2_framing", fe_cnt, 0);
    check("t2_overrun", ov_cnt, 0);

    // 3: low stop bit, long break, then a good byte
    clr();
    @(posedge clk);
    send_byte(8'h3C, 1'b0);
    for (int i = 0; i < 40; i++) drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    check("t3_framing_cnt", fe_cnt, 1);
    check("t3_no_valid", rise_cnt, 0);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    repeat (4) @(posedge clk);
    check("t3_framing_after", fe_cnt, 1);
    check("t3_rise_cnt", rise_cnt, 1);
    check("t3_sb_empty", exp_q.size(), 0);

`ifndef UART_RX_FIFO_EN
    // 4: holding register overrun, then same-cycle pop/push when full
    @(posedge clk); #1 rx_ready = 1'b0; clr();
    @(posedge clk);
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t4_overrun_cnt", ov_cnt, 1);
    check("t4_overrun_time", ov_cyc - fall_cyc, 79);
    check("t4_valid_held", rx_valid, 1);
    check("t4_data_held", rx_data, 8'h11);
    @(posedge clk);
    exp_q.push_back(8'h22);
    fork
      send_byte(8'h22, 1'b1);
      begin
        repeat (78) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t4_no_new_overrun", ov_cnt, 1);
    check("t4_valid_new", rx_valid, 1);
    check("t4_data_new", rx_data, 8'h22);
    @(posedge clk); #1 rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t4_sb_empty", exp_q.size(), 0);
    check("t4_drained", rx_valid, 0);
`else
    // 5: FIFO fills at 4, fifth byte overruns, drain in order
    @(posedge clk); #1 rx_ready = 1'b0; clr();
    @(posedge clk);
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t5_overrun_cnt", ov_cnt, 1);
    check("t5_overrun_time", ov_cyc - fall_cyc, 79);
    check("t5_head", rx_data, 8'h01);
    @(posedge clk); #1 rx_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("t5_sb_empty", exp_q.size(), 0);
    check("t5_drained", rx_valid, 0);
`endif

    // 6: reset during data bit 4, then a clean byte
    @(posedge clk); #1 rx_ready = 1'b1; clr();
    @(posedge clk);
    fork
      send_byte(8'hF0, 1'b1);
      begin
        repeat (43) @(posedge clk);
        @(negedge clk);
        check("t6_busy_before", busy, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t6_rst_valid", rx_valid, 0);
        check("t6_rst_data", rx_data, 8'h00);
        check("t6_rst_framing", framing_err, 0);
        check("t6_rst_overrun", overrun, 0);
        check("t6_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    check("t6_no_abort_output", rise_cnt, 0);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    repeat (4) @(posedge clk);
    check("t6_rise_cnt", rise_cnt, 1);
    check("t6_framing", fe_cnt, 0);
    check("t6_overrun", ov_cnt, 0);
    check("t6_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
